// File: rtl/life_grid_engine.sv
// life_grid_engine: W x H Game of Life grid evolved by a single row-sweep datapath.
// One row of update units processes one row per clock; a shadow copy of the grid
// is published at the end of each generation for the display reader.
// Optional feature macro: LIFE_HALT_ON_STABLE_EN (halt free-running evolution once
// a generation leaves every cell unchanged).
module life_grid_engine #(
    parameter int unsigned W     = 8,
    parameter int unsigned H     = 8,
    parameter int unsigned GEN_W = 16,
    parameter logic [W*H-1:0] INIT_PATTERN = '0
) (
    input  logic                         qzt_clk,
    input  logic                         rst,
    input  logic                         tick,
    input  logic                         run,
    input  logic                         step,
    input  logic                         wrap_en,
    input  logic                         load_we,
    input  logic [$clog2(H)-1:0]         load_row,
    input  logic [W-1:0]                 load_data,
    input  logic [9:0]                   rd_x,
    input  logic [9:0]                   rd_y,
    output logic                         rd_cell,
    output logic                         busy,
    output logic                         gen_done,
    output logic [GEN_W-1:0]             gen_count,
    output logic [$clog2(W*H+1)-1:0]     population,
    output logic                         extinct,
    output logic                         overrun,
    output logic                         stable
);

    localparam int unsigned RW = $clog2(H);
    localparam int unsigned XW = $clog2(W);
    localparam int unsigned PW = $clog2(W*H+1);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t         state_q;
    logic [RW-1:0]  row_q;
    logic [W-1:0]   grid_q   [H];
    logic [W-1:0]   shadow_q [H];
    logic [W-1:0]   prev_q;
    logic [W-1:0]   row0_save_q;
    logic           wrap_q;
    logic [PW-1:0]  pop_acc_q;

    logic [RW-1:0]  dn_idx_c;
    logic [W-1:0]   up_row_c;
    logic [W-1:0]   dn_row_c;
    logic [W-1:0]   new_row_c;
    logic [PW-1:0]  row_pop_c;
    logic           load_c;
    logic           start_c;

    // B3/S23 update of one row given its upper and lower neighbour rows.
    function automatic logic [W-1:0] life_row(input logic [W-1:0] up,
                                              input logic [W-1:0] cur,
                                              input logic [W-1:0] dn,
                                              input logic         wrap);
        logic [W+1:0] eu, ec, ed;
        logic [3:0]   n;
        logic [W-1:0] res;
        eu  = {wrap & up[0],  up,  wrap & up[W-1]};
        ec  = {wrap & cur[0], cur, wrap & cur[W-1]};
        ed  = {wrap & dn[0],  dn,  wrap & dn[W-1]};
        res = '0;
        for (int x = 0; x < int'(W); x++) begin
            n = 4'(eu[x]) + 4'(eu[x+1]) + 4'(eu[x+2]) + 4'(ec[x]) + 4'(ec[x+2])
              + 4'(ed[x]) + 4'(ed[x+1]) + 4'(ed[x+2]);
            res[x] = (n == 4'd3) | (cur[x] & (n == 4'd2));
        end
        return res;
    endfunction

    // Number of live cells in one row.
    function automatic logic [PW-1:0] row_popcount(input logic [W-1:0] v);
        logic [PW-1:0] s;
        s = '0;
        for (int x = 0; x < int'(W); x++) begin
            s = s + PW'(v[x]);
        end
        return s;
    endfunction

    // Neighbour row selection and the new-row datapath for the current sweep row.
    always_comb begin
        dn_idx_c = (row_q == RW'(H-1)) ? '0 : row_q + 1'b1;
        up_row_c = prev_q;
        if (!wrap_q && (row_q == '0)) begin
            up_row_c = '0;
        end
        dn_row_c = grid_q[dn_idx_c];
        if (row_q == RW'(H-1)) begin
            dn_row_c = wrap_q ? row0_save_q : '0;
        end
        new_row_c = life_row(up_row_c, grid_q[row_q], dn_row_c, wrap_q);
        row_pop_c = row_popcount(new_row_c);
    end

    // Loads only land while idle and take priority over a start request.
    assign load_c  = (state_q == IDLE) && load_we;
    assign start_c = (state_q == IDLE) && !load_we && ((run && tick && !stable) || step);

    // Control FSM, grid/shadow storage and generation statistics.
    always_ff @(posedge qzt_clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            prev_q      <= '0;
            row0_save_q <= '0;
            wrap_q      <= 1'b0;
            pop_acc_q   <= '0;
            busy        <= 1'b0;
            gen_done    <= 1'b0;
            gen_count   <= '0;
            population  <= '0;
            extinct     <= 1'b0;
            overrun     <= 1'b0;
            for (int i = 0; i < int'(H); i++) begin
                grid_q[i]   <= INIT_PATTERN[W*i +: W];
                shadow_q[i] <= INIT_PATTERN[W*i +: W];
            end
        end else begin
            gen_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_c) begin
                        if (32'(load_row) < H) begin
                            grid_q[load_row]   <= load_data;
                            shadow_q[load_row] <= load_data;
                        end
                        overrun <= 1'b0;
                    end else if (start_c) begin
                        row0_save_q <= grid_q[0];
                        prev_q      <= grid_q[H-1];
                        row_q       <= '0;
                        wrap_q      <= wrap_en;
                        pop_acc_q   <= '0;
                        busy        <= 1'b1;
                        state_q     <= SWEEP;
                    end
                end
                SWEEP: begin
                    grid_q[row_q] <= new_row_c;
                    prev_q        <= grid_q[row_q];
                    pop_acc_q     <= pop_acc_q + row_pop_c;
                    if (tick || step) begin
                        overrun <= 1'b1;
                    end
                    if (row_q == RW'(H-1)) begin
                        state_q <= DONE;
                    end else begin
                        row_q <= row_q + 1'b1;
                    end
                end
                DONE: begin
                    shadow_q   <= grid_q;
                    gen_count  <= gen_count + 1'b1;
                    population <= pop_acc_q;
                    extinct    <= (pop_acc_q == '0);
                    gen_done   <= 1'b1;
                    busy       <= 1'b0;
                    row_q      <= '0;
                    if (tick || step) begin
                        overrun <= 1'b1;
                    end
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef LIFE_HALT_ON_STABLE_EN
    logic changed_q;

    // Track whether any cell changed during the sweep; publish at the end of the generation.
    always_ff @(posedge qzt_clk or posedge rst) begin
        if (rst) begin
            changed_q <= 1'b0;
            stable    <= 1'b0;
        end else if (load_c) begin
            stable <= 1'b0;
        end else if (start_c) begin
            changed_q <= 1'b0;
        end else if (state_q == SWEEP) begin
            changed_q <= changed_q | (|(new_row_c ^ grid_q[row_q]));
        end else if (state_q == DONE) begin
            stable <= ~changed_q;
        end
    end
`else
    assign stable = 1'b0;
`endif

    // Display read port from the shadow copy; off-grid coordinates read as dead.
    always_ff @(posedge qzt_clk or posedge rst) begin
        if (rst) begin
            rd_cell <= 1'b0;
        end else if ((32'(rd_x) < W) && (32'(rd_y) < H)) begin
            rd_cell <= shadow_q[rd_y[RW-1:0]][rd_x[XW-1:0]];
        end else begin
            rd_cell <= 1'b0;
        end
    end

endmodule

// File: tb/tb_life_grid_engine.sv
// Directed testbench for life_grid_engine (W=H=8, vertical blinker initial pattern).
module tb_life_grid_engine;

    localparam logic [63:0] INIT   = (64'd1 << 43) | (64'd1 << 51) | (64'd1 << 59);
    localparam logic [63:0] HORIZ  = (64'd1 << 50) | (64'd1 << 51) | (64'd1 << 52);
    localparam logic [63:0] GLIDER = 64'h0000_0000_0007_0402;
    localparam logic [63:0] BLOCK  = 64'hC0C0_0000_0000_0000;
    localparam logic [63:0] SINGLE = 64'd1 << 36;

    logic        qzt_clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0, run = 1'b0, step = 1'b0, wrap_en = 1'b0, load_we = 1'b0;
    logic [2:0]  load_row = '0;
    logic [7:0]  load_data = '0;
    logic [9:0]  rd_x = '0, rd_y = '0;
    logic        rd_cell, busy, gen_done, extinct, overrun, stable;
    logic [15:0] gen_count;
    logic [6:0]  population;

    int n_checks = 0;
    int n_pass   = 0;

    life_grid_engine #(.W(8), .H(8), .GEN_W(16), .INIT_PATTERN(INIT)) dut (
        .qzt_clk(qzt_clk), .rst(rst), .tick(tick), .run(run), .step(step),
        .wrap_en(wrap_en), .load_we(load_we), .load_row(load_row), .load_data(load_data),
        .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_cell), .busy(busy), .gen_done(gen_done),
        .gen_count(gen_count), .population(population), .extinct(extinct),
        .overrun(overrun), .stable(stable)
    );

    always #10 qzt_clk = ~qzt_clk;

    task automatic cyc();
        @(posedge qzt_clk);
        #1;
    endtask

    task automatic pulse_step();
        step = 1'b1; cyc(); step = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1; cyc(); tick = 1'b0;
    endtask

    task automatic wait_done(input string name, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            lat++;
            if (gen_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) $display("FAIL %s_gen_done: got no pulse in 40 cycles, want pulse", name);
        else n_pass++;
    endtask

    task automatic load_grid(input logic [63:0] g);
        for (int r = 0; r < 8; r++) begin
            load_we = 1'b1; load_row = 3'(r); load_data = g[8*r +: 8];
            cyc();
        end
        load_we = 1'b0;
    endtask

    task automatic read_grid(output logic [63:0] g);
        g = '0;
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                rd_x = 10'(x); rd_y = 10'(y);
                cyc();
                g[8*y+x] = rd_cell;
            end
        end
    endtask

    task automatic test_reset();
        logic [63:0] g;
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (gen_done !== 1'b0) $display("FAIL reset_gen_done: got %b want 0", gen_done); else n_pass++;
        n_checks++; if (gen_count !== 16'd0) $display("FAIL reset_gen_count: got %0d want 0", gen_count); else n_pass++;
        n_checks++; if (population !== 7'd0) $display("FAIL reset_population: got %0d want 0", population); else n_pass++;
        n_checks++; if (extinct !== 1'b0) $display("FAIL reset_extinct: got %b want 0", extinct); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else n_pass++;
        n_checks++; if (stable !== 1'b0) $display("FAIL reset_stable: got %b want 0", stable); else n_pass++;
        read_grid(g);
        n_checks++; if (g !== INIT) $display("FAIL reset_grid: got %h want %h", g, INIT); else n_pass++;
    endtask

    task automatic test_blinker();
        logic [63:0] g;
        int lat;
        logic [9:0] xs [6] = '{10'd3, 10'd11, 10'd3,  10'd8, 10'd3, 10'd4};
        logic [9:0] ys [6] = '{10'd6, 10'd6,  10'd14, 10'd6, 10'd8, 10'd6};
        logic       ex [6] = '{1'b1,  1'b0,   1'b0,   1'b0,  1'b0,  1'b0};
        wrap_en = 1'b0;
        pulse_step();
        n_checks++; if (busy !== 1'b1) $display("FAIL blinker_busy_start: got %b want 1", busy); else n_pass++;
        wait_done("blinker1", lat);
        n_checks++; if (lat != 9) $display("FAIL blinker_latency: got %0d want 9", lat); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL blinker_busy_end: got %b want 0", busy); else n_pass++;
        n_checks++; if (gen_count !== 16'd1) $display("FAIL blinker_gen_count1: got %0d want 1", gen_count); else n_pass++;
        n_checks++; if (population !== 7'd3) $display("FAIL blinker_population: got %0d want 3", population); else n_pass++;
        n_checks++; if (extinct !== 1'b0) $display("FAIL blinker_extinct: got %b want 0", extinct); else n_pass++;
        cyc();
        n_checks++; if (gen_done !== 1'b0) $display("FAIL blinker_done_pulse_width: got %b want 0", gen_done); else n_pass++;
        read_grid(g);
        n_checks++; if (g !== HORIZ) $display("FAIL blinker_grid1: got %h want %h", g, HORIZ); else n_pass++;
        pulse_step();
        wait_done("blinker2", lat);
        n_checks++; if (gen_count !== 16'd2) $display("FAIL blinker_gen_count2: got %0d want 2", gen_count); else n_pass++;
        read_grid(g);
        n_checks++; if (g !== INIT) $display("FAIL blinker_grid2: got %h want %h", g, INIT); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            rd_x = xs[i]; rd_y = ys[i];
            cyc();
            n_checks++;
            if (rd_cell !== ex[i]) $display("FAIL rd_cell_%0d_%0d: got %b want %b", xs[i], ys[i], rd_cell, ex[i]);
            else n_pass++;
        end
    endtask

    task automatic test_extinct();
        logic [63:0] g;
        int lat;
        logic [15:0] g0;
        load_grid(SINGLE);
        read_grid(g);
        n_checks++; if (g !== SINGLE) $display("FAIL extinct_load_shadow: got %h want %h", g, SINGLE); else n_pass++;
        g0 = gen_count;
        wrap_en = 1'b1;
        pulse_step();
        wait_done("extinct", lat);
        n_checks++; if (population !== 7'd0) $display("FAIL extinct_population: got %0d want 0", population); else n_pass++;
        n_checks++; if (extinct !== 1'b1) $display("FAIL extinct_flag: got %b want 1", extinct); else n_pass++;
        n_checks++; if (gen_count !== 16'(g0 + 1)) $display("FAIL extinct_gen_count: got %0d want %0d", gen_count, g0 + 1); else n_pass++;
    endtask

    task automatic test_glider_wrap();
        logic [63:0] g;
        int lat;
        logic [15:0] g0;
        load_grid(GLIDER);
        wrap_en = 1'b1;
        run = 1'b1;
        g0 = gen_count;
        for (int k = 0; k < 32; k++) begin
            pulse_tick();
            wait_done("glider_wrap", lat);
            n_checks++;
            if (population !== 7'd5) $display("FAIL glider_wrap_pop_gen%0d: got %0d want 5", k + 1, population);
            else n_pass++;
            repeat (10) cyc();
        end
        run = 1'b0;
        n_checks++; if (gen_count !== 16'(g0 + 32)) $display("FAIL glider_wrap_gen_count: got %0d want %0d", gen_count, g0 + 32); else n_pass++;
        n_checks++; if (extinct !== 1'b0) $display("FAIL glider_wrap_extinct: got %b want 0", extinct); else n_pass++;
        read_grid(g);
        n_checks++; if (g !== GLIDER) $display("FAIL glider_wrap_grid: got %h want %h", g, GLIDER); else n_pass++;
    endtask

    task automatic test_glider_dead();
        logic [63:0] g;
        int lat;
        logic [15:0] g1;
        load_grid(GLIDER);
        wrap_en = 1'b0;
        run = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            pulse_tick();
            wait_done("glider_dead", lat);
            if (k >= 23) begin
                n_checks++;
                if (population !== 7'd4) $display("FAIL glider_dead_pop_gen%0d: got %0d want 4", k, population);
                else n_pass++;
            end
            repeat (10) cyc();
        end
        read_grid(g);
        n_checks++; if (g !== BLOCK) $display("FAIL glider_dead_grid: got %h want %h", g, BLOCK); else n_pass++;
        g1 = gen_count;
`ifdef LIFE_HALT_ON_STABLE_EN
        n_checks++; if (stable !== 1'b1) $display("FAIL glider_dead_stable: got %b want 1", stable); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            pulse_tick();
            repeat (19) cyc();
        end
        n_checks++; if (gen_count !== g1) $display("FAIL stable_halt_gen_count: got %0d want %0d", gen_count, g1); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL stable_halt_overrun: got %b want 0", overrun); else n_pass++;
        pulse_step();
        wait_done("stable_step", lat);
        n_checks++; if (gen_count !== 16'(g1 + 1)) $display("FAIL stable_step_gen_count: got %0d want %0d", gen_count, g1 + 1); else n_pass++;
        n_checks++; if (stable !== 1'b1) $display("FAIL stable_after_step: got %b want 1", stable); else n_pass++;
`else
        n_checks++; if (stable !== 1'b0) $display("FAIL glider_dead_stable: got %b want 0", stable); else n_pass++;
        pulse_tick();
        wait_done("no_halt", lat);
        n_checks++; if (gen_count !== 16'(g1 + 1)) $display("FAIL no_halt_gen_count: got %0d want %0d", gen_count, g1 + 1); else n_pass++;
        n_checks++; if (population !== 7'd4) $display("FAIL no_halt_population: got %0d want 4", population); else n_pass++;
`endif
        run = 1'b0;
    endtask

    task automatic test_overrun();
        int lat;
        logic [15:0] g0;
        load_grid(GLIDER);
        wrap_en = 1'b1;
        run = 1'b1;
        g0 = gen_count;
        pulse_tick();
        cyc(); cyc();
        tick = 1'b1; load_we = 1'b1; load_row = 3'd7; load_data = 8'hFF;
        cyc();
        tick = 1'b0; load_we = 1'b0;
        wait_done("overrun", lat);
        n_checks++; if (overrun !== 1'b1) $display("FAIL overrun_set: got %b want 1", overrun); else n_pass++;
        n_checks++; if (population !== 7'd5) $display("FAIL overrun_load_ignored_pop: got %0d want 5", population); else n_pass++;
        n_checks++; if (gen_count !== 16'(g0 + 1)) $display("FAIL overrun_gen_count: got %0d want %0d", gen_count, g0 + 1); else n_pass++;
        repeat (20) cyc();
        n_checks++; if (gen_count !== 16'(g0 + 1)) $display("FAIL overrun_no_extra_gen: got %0d want %0d", gen_count, g0 + 1); else n_pass++;
        run = 1'b0;
        load_grid(GLIDER);
        n_checks++; if (overrun !== 1'b0) $display("FAIL overrun_cleared_by_load: got %b want 0", overrun); else n_pass++;
        load_we = 1'b1; load_row = 3'd0; load_data = 8'h02; step = 1'b1;
        cyc();
        load_we = 1'b0; step = 1'b0;
        cyc();
        n_checks++; if (busy !== 1'b0) $display("FAIL load_beats_step_busy: got %b want 0", busy); else n_pass++;
        repeat (12) cyc();
        n_checks++; if (gen_count !== 16'(g0 + 1)) $display("FAIL load_beats_step_gen_count: got %0d want %0d", gen_count, g0 + 1); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL load_beats_step_overrun: got %b want 0", overrun); else n_pass++;
    endtask

    task automatic test_reset_midsweep();
        logic [63:0] g;
        int lat;
        rd_x = 10'd1; rd_y = 10'd0;
        pulse_step();
        cyc(); cyc(); cyc();
        n_checks++; if (rd_cell !== 1'b1) $display("FAIL midsweep_rd_before: got %b want 1", rd_cell); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL midsweep_busy_before: got %b want 1", busy); else n_pass++;
        rst = 1'b1;
        #2;
        n_checks++; if (busy !== 1'b0) $display("FAIL midsweep_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (gen_done !== 1'b0) $display("FAIL midsweep_gen_done: got %b want 0", gen_done); else n_pass++;
        n_checks++; if (gen_count !== 16'd0) $display("FAIL midsweep_gen_count: got %0d want 0", gen_count); else n_pass++;
        n_checks++; if (population !== 7'd0) $display("FAIL midsweep_population: got %0d want 0", population); else n_pass++;
        n_checks++; if (extinct !== 1'b0) $display("FAIL midsweep_extinct: got %b want 0", extinct); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL midsweep_overrun: got %b want 0", overrun); else n_pass++;
        n_checks++; if (stable !== 1'b0) $display("FAIL midsweep_stable: got %b want 0", stable); else n_pass++;
        n_checks++; if (rd_cell !== 1'b0) $display("FAIL midsweep_rd_cell: got %b want 0", rd_cell); else n_pass++;
        cyc();
        rst = 1'b0;
        cyc();
        read_grid(g);
        n_checks++; if (g !== INIT) $display("FAIL midsweep_grid: got %h want %h", g, INIT); else n_pass++;
        wrap_en = 1'b0;
        pulse_step();
        wait_done("midsweep_after", lat);
        n_checks++; if (gen_count !== 16'd1) $display("FAIL midsweep_after_gen_count: got %0d want 1", gen_count); else n_pass++;
        read_grid(g);
        n_checks++; if (g !== HORIZ) $display("FAIL midsweep_after_grid: got %h want %h", g, HORIZ); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_blinker();
        test_extinct();
        test_glider_wrap();
        test_glider_dead();
        test_overrun();
        test_reset_midsweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
